// File: rtl/hdmi_clk_rst_mgr.sv
// ---------------------------------------------------------------------------
// hdmi_clk_rst_mgr
//
// Clock-health and reset sequencer that sits beside the HDMI/display PLL.
// It holds the PLL in reset and releases it. It then waits for the PLL lock
// flag, which is synchronised into refclk. Lock must stay stable for a
// qualification window before anything is released. After that, the
// per-domain resets are released one at a time in a staggered order.
// The block re-locks automatically if lock is lost, and it re-locks on a
// software request. If lock never arrives, it retries a fixed number of
// times and then parks in a failure state until software asks again.
//
// Ports:
//   refclk          in   free-running reference clock (PLL refclk source)
//   rst_n           in   asynchronous active-low reset
//   extlock_i       in   PLL lock flag, asynchronous to refclk
//   relock_req_i    in   software re-lock request (level, sampled per cycle)
//   pll_reset_o     out  active-high PLL reset
//   dom_rst_n_o     out  active-low per-domain resets, bit i released i-th
//   clk_ok_o        out  all domains released and lock healthy
//   lock_fail_o     out  lock timeouts exhausted, waiting for software
//   retry_cnt_o     out  lock timeouts since the last successful RUN
//   lock_loss_cnt_o out  (HDMI_CLK_RST_LOSS_CNT_EN only) saturating count of
//                        lock losses seen while running
//
// Optional feature macro: HDMI_CLK_RST_LOSS_CNT_EN
// ---------------------------------------------------------------------------
module hdmi_clk_rst_mgr #(
    parameter int NUM_DOMAINS      = 3,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int RST_STAGGER_CYC  = 8,
    parameter int MAX_RETRY        = 3
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   extlock_i,
    input  logic                   relock_req_i,
    output logic                   pll_reset_o,
    output logic [NUM_DOMAINS-1:0] dom_rst_n_o,
    output logic                   clk_ok_o,
    output logic                   lock_fail_o,
    output logic [3:0]             retry_cnt_o
`ifdef HDMI_CLK_RST_LOSS_CNT_EN
    ,
    output logic [15:0]            lock_loss_cnt_o
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The last domain rises this many cycles after RELEASE is entered.
    localparam int RELEASE_LEN = (NUM_DOMAINS - 1) * RST_STAGGER_CYC;
    localparam int MAX_CYC     = max2(max2(PLL_RST_CYC, LOCK_TIMEOUT_CYC),
                                      max2(LOCK_STABLE_CYC, RELEASE_LEN));
    localparam int CW          = $clog2(MAX_CYC) + 1;

    // Each counter is compared against the index of the last cycle in its state.
    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_LEN);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          lock_meta;
    logic          lock_s;

    assign cnt_next = cnt + 1'b1;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= extlock_i;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer. All outputs are registered here. The one shared counter
    // restarts from zero whenever a state is entered.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset_o <= 1'b1;
            dom_rst_n_o <= '0;
            clk_ok_o    <= 1'b0;
            lock_fail_o <= 1'b0;
            retry_cnt_o <= 4'd0;
        end else begin
            case (state)
                PLL_RST: begin
                    // A software request while holding simply restarts the hold.
                    if (relock_req_i) begin
                        cnt <= '0;
                    end else if (cnt == PLL_RST_LAST) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        pll_reset_o <= 1'b0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end

                WAIT_LOCK: begin
                    // Lock takes priority over a timeout in the same cycle.
                    if (relock_req_i) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_o <= 1'b1;
                    end else if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        pll_reset_o <= 1'b1;
                        retry_cnt_o <= retry_cnt_o + 4'd1;
                        if (retry_cnt_o + 4'd1 == RETRY_LIMIT) begin
                            state       <= FAIL;
                            lock_fail_o <= 1'b1;
                        end else begin
                            state <= PLL_RST;
                        end
                    end else begin
                        cnt <= cnt_next;
                    end
                end

                STABLE: begin
                    if (relock_req_i) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_o <= 1'b1;
                    end else if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        // Domain 0 is released together with entry into RELEASE.
                        state          <= RELEASE;
                        cnt            <= '0;
                        dom_rst_n_o[0] <= 1'b1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end

                RELEASE: begin
                    if (relock_req_i || !lock_s) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_o <= 1'b1;
                        dom_rst_n_o <= '0;
                    end else if (cnt == RELEASE_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        clk_ok_o    <= 1'b1;
                        retry_cnt_o <= 4'd0;
                    end else begin
                        // Bit i rises once i*RST_STAGGER_CYC cycles have elapsed.
                        cnt <= cnt_next;
                        for (int i = 1; i < NUM_DOMAINS; i++) begin
                            if (cnt_next == CW'(i * RST_STAGGER_CYC)) begin
                                dom_rst_n_o[i] <= 1'b1;
                            end
                        end
                    end
                end

                RUN: begin
                    if (relock_req_i || !lock_s) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_o <= 1'b1;
                        dom_rst_n_o <= '0;
                        clk_ok_o    <= 1'b0;
                    end
                end

                FAIL: begin
                    if (relock_req_i) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        lock_fail_o <= 1'b0;
                        retry_cnt_o <= 4'd0;
                    end
                end

                default: begin
                    state       <= PLL_RST;
                    cnt         <= '0;
                    pll_reset_o <= 1'b1;
                    dom_rst_n_o <= '0;
                    clk_ok_o    <= 1'b0;
                    lock_fail_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef HDMI_CLK_RST_LOSS_CNT_EN
    // Only a genuine lock drop in RUN counts. A drop that coincides with a
    // software request is treated as the request.
    logic loss_event;
    assign loss_event = (state == RUN) && !lock_s && !relock_req_i;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt_o <= 16'd0;
        end else if (loss_event && (lock_loss_cnt_o != 16'hFFFF)) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
        end
    end
`endif

endmodule
